// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: data width,
// 4-bit opcode encoding of the shared ALU, FSM states and operand bundle.
package alu_arbiter_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_XNOR = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Everything captured from a requester at the moment it is granted.
  typedef struct packed {
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
    logic              id;
  } operand_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared 16-bit combinational ALU. Carry is meaningful only for add, sub and
// the undefined codes, which fall back to add-with-carry. Sub computes
// A - B - cin and reports a borrow in carry. Shifts move A by one bit.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_cin,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry
);

  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic [2*DATA_W-1:0] w_prod;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + {{DATA_W{1'b0}}, i_cin};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b} - {{DATA_W{1'b0}}, i_cin};
  assign w_prod = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};

  // Select the operation result; a zero divisor yields 0 here and is
  // replaced by the arbiter's configured value.
  always_comb begin
    // NOTE: outputs get defaults first so no path through the case infers a latch.
    o_result = '0;
    o_carry  = 1'b0;
    case (i_op)
      OP_ADD:  {o_carry, o_result} = w_sum;
      OP_SUB:  {o_carry, o_result} = w_diff;
      OP_MUL:  o_result = w_prod[DATA_W-1:0];
      OP_DIV:  o_result = (i_b == '0) ? '0 : i_a / i_b;
      OP_SHL:  o_result = i_a << 1;
      OP_SHR:  o_result = i_a >> 1;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOR:  o_result = ~(i_a | i_b);
      OP_NAND: o_result = ~(i_a & i_b);
      OP_XNOR: o_result = ~(i_a ^ i_b);
      default: {o_carry, o_result} = w_sum;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU. A round-robin grant in IDLE
// captures the winner's operands, EXEC runs the ALU from those registers
// for one cycle, RESP holds the registered response until it is taken.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter logic [DATA_W-1:0] DIV0_VALUE = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_cin,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_div0,
  output logic              busy
);

  state_t            r_state;
  operand_t          r_opnd;
  logic              r_last_grant;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_result;
  logic              r_rsp_carry;
  logic              r_rsp_div0;

  logic              w_grant_id;
  logic              w_accept;
  operand_t          w_req0;
  operand_t          w_req1;
  operand_t          w_sel;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_carry;
  logic              w_div0;

  // A lone requester wins; on a contest the one not granted last time wins.
  assign w_grant_id = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  assign w_accept   = (r_state == ST_IDLE) && (req0_valid || req1_valid) && !rst;
  assign req0_ready = w_accept && !w_grant_id;
  assign req1_ready = w_accept &&  w_grant_id;

  assign w_req0 = '{op: req0_op, a: req0_a, b: req0_b, cin: req0_cin, id: 1'b0};
  assign w_req1 = '{op: req1_op, a: req1_a, b: req1_b, cin: req1_cin, id: 1'b1};
  assign w_sel  = w_grant_id ? w_req1 : w_req0;

  assign w_div0 = (r_opnd.op == OP_DIV) && (r_opnd.b == '0);

  alu u_alu (
    .i_op     (r_opnd.op),
    .i_a      (r_opnd.a),
    .i_b      (r_opnd.b),
    .i_cin    (r_opnd.cin),
    .o_result (w_alu_result),
    .o_carry  (w_alu_carry)
  );

  // Arbitration FSM with operand capture and registered response.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state      <= ST_IDLE;
      r_opnd       <= '0;
      r_last_grant <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_div0   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_opnd       <= w_sel;
            r_last_grant <= w_grant_id;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_result <= w_div0 ? DIV0_VALUE : w_alu_result;
          r_rsp_carry  <= w_alu_carry && !w_div0;
          r_rsp_div0   <= w_div0;
          r_rsp_id     <= r_opnd.id;
          r_rsp_valid  <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_div0   = r_rsp_div0;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: grants push the expected response onto a
// scoreboard, and every consumed response is popped and compared.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_cin;
  logic [3:0]  req0_op;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [3:0]  req1_op;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_div0, busy;
  logic [15:0] rsp_result;

  typedef struct {
    logic        id;
    logic [15:0] result;
    logic        carry;
    logic        div0;
  } rsp_t;

  rsp_t sb[$];
  int   grant_id_q[$];
  int   grant_cyc_q[$];
  int   cyc = 0;
  int   last_grant_cyc = 0;
  logic prev_rsp_valid = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_div0   (rsp_div0),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of the arbiter's response for one operation.
  function automatic rsp_t model(input logic id, input logic [3:0] op,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic cin);
    rsp_t   r;
    longint s;
    r.id    = id;
    r.carry = 1'b0;
    r.div0  = 1'b0;
    r.result = 16'h0;
    case (op)
      4'h1: begin
        s = longint'(a) - longint'(b) - longint'(cin);
        r.result = s[15:0];
        r.carry  = (s < 0);
      end
      4'h2: begin
        s = longint'(a) * longint'(b);
        r.result = s[15:0];
      end
      4'h3: begin
        if (b == 16'h0) begin
          r.result = 16'hFFFF;
          r.div0   = 1'b1;
        end else begin
          r.result = a / b;
        end
      end
      4'h4: r.result = {a[14:0], 1'b0};
      4'h5: r.result = {1'b0, a[15:1]};
      4'h8: r.result = a & b;
      4'h9: r.result = a | b;
      4'hA: r.result = a ^ b;
      4'hB: r.result = ~(a | b);
      4'hC: r.result = ~(a & b);
      4'hD: r.result = ~(a ^ b);
      default: begin
        s = longint'(a) + longint'(b) + longint'(cin);
        r.result = s[15:0];
        r.carry  = s[16];
      end
    endcase
    return r;
  endfunction

  function automatic logic ready_of(input logic id);
    return id ? req1_ready : req0_ready;
  endfunction

  // Per-cycle monitor: handshake rules, grant log, scoreboard push/pop.
  always @(negedge clk) begin
    rsp_t e;
    check("ready_rules",
          32'(!(req0_ready && req1_ready) && (!req0_ready || req0_valid) &&
              (!req1_ready || req1_valid) && (!(req0_ready || req1_ready) || !busy)),
          32'd1);
    if (req0_ready || req1_ready) begin
      if (req1_ready) sb.push_back(model(1'b1, req1_op, req1_a, req1_b, req1_cin));
      else            sb.push_back(model(1'b0, req0_op, req0_a, req0_b, req0_cin));
      grant_id_q.push_back(req1_ready ? 1 : 0);
      grant_cyc_q.push_back(cyc);
      last_grant_cyc = cyc;
    end
    if (rsp_valid && !prev_rsp_valid) check("latency", 32'(cyc - last_grant_cyc), 32'd2);
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL unexpected_rsp: observed response for id %0d expected none", rsp_id);
      end else begin
        e = sb.pop_front();
        check("sb_id",     32'(rsp_id),     32'(e.id));
        check("sb_result", 32'(rsp_result), 32'(e.result));
        check("sb_carry",  32'(rsp_carry),  32'(e.carry));
        check("sb_div0",   32'(rsp_div0),   32'(e.div0));
      end
    end
    prev_rsp_valid = rsp_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic cin);
    if (id) begin
      req1_op = op; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_op = op; req0_a = a; req0_b = b; req0_cin = cin;
    end
  endtask

  // Present one request, wait for its grant, then scramble the inputs.
  task automatic issue(input logic id, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic cin);
    int k;
    tick();
    drive(id, op, a, b, cin);
    if (id) req1_valid = 1'b1; else req0_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!ready_of(id) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("grant", 32'(ready_of(id)), 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drive(1'b0, 4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    drive(1'b1, 4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    @(negedge clk);
    check("exec_busy",   32'(busy),      32'd1);
    check("exec_no_rsp", 32'(rsp_valid), 32'd0);
  endtask

  task automatic wait_rsp();
    int k;
    k = 0;
    while (!rsp_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("rsp_seen", 32'(rsp_valid), 32'd1);
  endtask

  task automatic run(input string tag, input logic id, input logic [3:0] op,
                     input logic [15:0] a, input logic [15:0] b, input logic cin,
                     input logic [15:0] exp_res, input logic exp_carry, input logic exp_div0);
    issue(id, op, a, b, cin);
    wait_rsp();
    check({tag, "_result"}, 32'(rsp_result), 32'(exp_res));
    check({tag, "_carry"},  32'(rsp_carry),  32'(exp_carry));
    check({tag, "_div0"},   32'(rsp_div0),   32'(exp_div0));
    check({tag, "_id"},     32'(rsp_id),     32'(id));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    grant_id_q.delete();
    grant_cyc_q.delete();
  endtask

  initial begin
    int k;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    drive(1'b0, 4'h0, 16'h0, 16'h0, 1'b0);
    drive(1'b1, 4'h0, 16'h0, 16'h0, 1'b0);

    // Reset: readies stay low even with both requesters valid.
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid),  32'd0);
    check("rst_busy",      32'(busy),       32'd0);
    check("rst_rsp_id",    32'(rsp_id),     32'd0);
    check("rst_result",    32'(rsp_result), 32'd0);
    check("rst_carry",     32'(rsp_carry),  32'd0);
    check("rst_div0",      32'(rsp_div0),   32'd0);

    // Single operations with the consumer always ready.
    rsp_ready = 1'b1;
    run("add_wrap",  1'b0, 4'h0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run("div_zero",  1'b1, 4'h3, 16'd100,  16'd0,    1'b0, 16'hFFFF, 1'b0, 1'b1);
    run("sub_borrow",1'b0, 4'h1, 16'd5,    16'd7,    1'b1, 16'hFFFD, 1'b1, 1'b0);
    run("mul_low",   1'b1, 4'h2, 16'h1234, 16'h0100, 1'b0, 16'h3400, 1'b0, 1'b0);
    run("shl",       1'b0, 4'h4, 16'h8001, 16'hFFFF, 1'b1, 16'h0002, 1'b0, 1'b0);
    run("shr",       1'b1, 4'h5, 16'h8001, 16'h1234, 1'b0, 16'h4000, 1'b0, 1'b0);
    run("div",       1'b0, 4'h3, 16'd100,  16'd7,    1'b0, 16'd14,   1'b0, 1'b0);
    run("xnor",      1'b1, 4'hD, 16'hF0F0, 16'hFF00, 1'b0, 16'hF00F, 1'b0, 1'b0);
    run("nor",       1'b0, 4'hB, 16'h00F0, 16'h0F00, 1'b0, 16'hF00F, 1'b0, 1'b0);
    run("undef6",    1'b1, 4'h6, 16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0, 1'b0);
    run("undefF",    1'b0, 4'hF, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // Contention right after reset: alternate 0,1,0,1 every 3 cycles.
    tick();
    do_reset();
    drive(1'b0, 4'h0, 16'd1, 16'd1, 1'b0);
    drive(1'b1, 4'h1, 16'd9, 16'd4, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (grant_id_q.size() < 4 && k < 40) begin
      @(negedge clk);
      k++;
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_count", 32'(grant_id_q.size()), 32'd4);
    if (grant_id_q.size() >= 4) begin
      check("rr_g0", 32'(grant_id_q[0]), 32'd0);
      check("rr_g1", 32'(grant_id_q[1]), 32'd1);
      check("rr_g2", 32'(grant_id_q[2]), 32'd0);
      check("rr_g3", 32'(grant_id_q[3]), 32'd1);
      for (int i = 1; i < 4; i++)
        check("rr_gap", 32'(grant_cyc_q[i] - grant_cyc_q[i-1]), 32'd3);
    end
    repeat (4) tick();

    // Backpressure: response holds, req0 waits, then wins right after release.
    rsp_ready = 1'b0;
    issue(1'b0, 4'h2, 16'd6, 16'd7, 1'b0);
    drive(1'b0, 4'h0, 16'd2, 16'd3, 1'b0);
    req0_valid = 1'b1;
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("hold_valid",  32'(rsp_valid),  32'd1);
      check("hold_result", 32'(rsp_result), 32'h002A);
      check("hold_ready0", 32'(req0_ready), 32'd0);
      check("hold_busy",   32'(busy),       32'd1);
    end
    tick();
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check("release_ready0", 32'(req0_ready), 32'd1);
    check("release_busy",   32'(busy),       32'd0);
    tick();
    req0_valid = 1'b0;
    wait_rsp();
    check("after_hold_result", 32'(rsp_result), 32'd5);

    // Reset in EXEC drops the operation; the next one still works.
    issue(1'b0, 4'h0, 16'd1, 16'd1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_busy",  32'(busy),      32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("abort_quiet", 32'(rsp_valid), 32'd0);
    end
    run("mul_after_abort", 1'b0, 4'h2, 16'd3, 16'd7, 1'b0, 16'd21, 1'b0, 1'b0);

    repeat (3) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion expected finish before timeout");
    $fatal(1, "timeout");
  end

endmodule
